src_dest_kiss_seq: RTL and testbench

- Multi-cycle sequencer for the ProgPoW src/dst KISS99 permutation.
- Computes the same result as the combinational src/dst shuffle: two Fisher-Yates shuffles of 0..31 driven by one KISS99 stream.
- Performs one KISS step and one swap per cycle.
- Streams the final KISS state and both permutation vectors into the exe_env u32 word store through a valid/ready write port.
- Sits between the op dispatcher (start/done) and the exe_env memory write arbiter.

---
 rtl/src_dest_kiss_seq.sv | 195 +++++++++++++++++++
 tb/tb_src_dest_kiss_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/src_dest_kiss_seq.sv
// src_dest_kiss_seq
//   Multi-cycle sequencer for the ProgPoW src/dst KISS99 permutation.
//   It runs two interleaved Fisher-Yates shuffles of 0..31 from one KISS99
//   stream, doing one KISS step and one swap per cycle. The results are then
//   streamed into the exe_env u32 word store over a valid/ready write port.
//
//   Build option: SRC_DEST_KISS_STATE_WB_EN
//     When defined, the four final KISS state words (z, w, jsr, jcong) are
//     written at kiss_base+0..3 ahead of the vectors, giving 68 writes.
//     When undefined, only the 64 vector writes are made.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     start                            request pulse, accepted only in IDLE
//     seed_z/w/jsr/jcong [31:0]        KISS seed, latched on accept
//     kiss_base/src_base/dst_base      word addresses, latched on accept
//     busy                             high in SHUF and WRITE
//     done                             one-cycle pulse after the last write
//     wr_valid/wr_ready/wr_addr/wr_data  exe_env write port
//
// state | meaning
// IDLE  | waiting for start
// SHUF  | one KISS step + one swap per cycle (62 cycles)
// WRITE | streaming state/vector words, advance on wr_valid & wr_ready
// DONE  | one-cycle done pulse, then IDLE
module src_dest_kiss_seq #(
  parameter int AW = 16,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   seed_z,
  input  logic [31:0]   seed_w,
  input  logic [31:0]   seed_jsr,
  input  logic [31:0]   seed_jcong,
  input  logic [AW-1:0] kiss_base,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          busy,
  output logic          done,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);

  typedef enum logic [1:0] {IDLE, SHUF, WRITE, DONE} state_t;

`ifdef SRC_DEST_KISS_STATE_WB_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int NW = HDR + 2 * N;

  localparam logic PH_DST = 1'b0;
  localparam logic PH_SRC = 1'b1;

  state_t        state, state_nxt;
  logic [31:0]   z_r, w_r, jsr_r, jcong_r;
  logic [AW-1:0] kiss_base_r, src_base_r, dst_base_r;
  logic [4:0]    src_r [N];
  logic [4:0]    dst_r [N];
  logic [4:0]    i_r;
  logic          phase_r;
  logic [6:0]    widx;

  logic [31:0] z_n, w_n, jsr_a, jsr_b, jsr_n, jcong_n, mwc, r;
  logic [4:0]  j;
  logic        in_hdr;
  logic [5:0]  vec_m;
  logic        shuf_last, wr_last;

  always_comb begin
    z_n     = 32'd36969 * {16'd0, z_r[15:0]} + {16'd0, z_r[31:16]};
    w_n     = 32'd18000 * {16'd0, w_r[15:0]} + {16'd0, w_r[31:16]};
    jsr_a   = jsr_r ^ (jsr_r << 17);
    jsr_b   = jsr_a ^ (jsr_a >> 13);
    jsr_n   = jsr_b ^ (jsr_b << 5);
    jcong_n = 32'd69069 * jcong_r + 32'd1234567;
    mwc     = (z_n << 16) + w_n;
    r       = (mwc ^ jcong_n) + jsr_n;
    // remainder is always below i+1 <= 32, so the low 5 bits carry it
    j       = 5'(r % ({27'd0, i_r} + 32'd1));
  end

`ifdef SRC_DEST_KISS_STATE_WB_EN
  assign in_hdr = (widx < 7'd4);
`else
  assign in_hdr = 1'b0;
`endif

  assign shuf_last = (i_r == 5'd1) && (phase_r == PH_SRC);
  assign wr_last   = (widx == 7'(NW - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHUF;
      SHUF:    if (shuf_last) state_nxt = WRITE;
      WRITE:   if (wr_ready && wr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      z_r         <= '0;
      w_r         <= '0;
      jsr_r       <= '0;
      jcong_r     <= '0;
      kiss_base_r <= '0;
      src_base_r  <= '0;
      dst_base_r  <= '0;
      i_r         <= '0;
      phase_r     <= PH_DST;
      widx        <= '0;
      for (int k = 0; k < N; k++) begin
        src_r[k] <= 5'(k);
        dst_r[k] <= 5'(k);
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            z_r         <= seed_z;
            w_r         <= seed_w;
            jsr_r       <= seed_jsr;
            jcong_r     <= seed_jcong;
            kiss_base_r <= kiss_base;
            src_base_r  <= src_base;
            dst_base_r  <= dst_base;
            i_r         <= 5'd31;
            phase_r     <= PH_DST;
            widx        <= '0;
            for (int k = 0; k < N; k++) begin
              src_r[k] <= 5'(k);
              dst_r[k] <= 5'(k);
            end
          end
        end
        SHUF: begin
          z_r     <= z_n;
          w_r     <= w_n;
          jsr_r   <= jsr_n;
          jcong_r <= jcong_n;
          // j == i writes the same value twice, which is the intended no-op
          if (phase_r == PH_DST) begin
            dst_r[i_r] <= dst_r[j];
            dst_r[j]   <= dst_r[i_r];
            phase_r    <= PH_SRC;
          end else begin
            src_r[i_r] <= src_r[j];
            src_r[j]   <= src_r[i_r];
            phase_r    <= PH_DST;
            i_r        <= i_r - 5'd1;
          end
        end
        WRITE: if (wr_ready) widx <= widx + 7'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state == SHUF) || (state == WRITE);
    done     = (state == DONE);
    wr_valid = (state == WRITE);
    vec_m    = widx[5:0] - 6'(HDR);
    wr_addr  = '0;
    wr_data  = '0;
    if (wr_valid) begin
      if (in_hdr) begin
        wr_addr = kiss_base_r + AW'(widx[1:0]);
        case (widx[1:0])
          2'd0:    wr_data = z_r;
          2'd1:    wr_data = w_r;
          2'd2:    wr_data = jsr_r;
          default: wr_data = jcong_r;
        endcase
      end else if (!vec_m[0]) begin
        wr_addr = src_base_r + AW'(vec_m[5:1]);
        wr_data = {27'd0, src_r[vec_m[5:1]]};
      end else begin
        wr_addr = dst_base_r + AW'(vec_m[5:1]);
        wr_data = {27'd0, dst_r[vec_m[5:1]]};
      end
    end
  end

endmodule

// File: tb/tb_src_dest_kiss_seq.sv
module tb_src_dest_kiss_seq;

`ifdef SRC_DEST_KISS_STATE_WB_EN
  localparam int NWORDS = 68;
  localparam int DONE_C = 131;
  localparam int HDRW   = 4;
`else
  localparam int NWORDS = 64;
  localparam int DONE_C = 127;
  localparam int HDRW   = 0;
`endif

  logic        clk, rst_n, start;
  logic [31:0] seed_z, seed_w, seed_jsr, seed_jcong;
  logic [15:0] kiss_base, src_base, dst_base;
  logic        busy, done, wr_valid, wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_addr [68];
  logic [31:0] exp_data [68];
  logic [31:0] got_data [68];

  src_dest_kiss_seq #(.AW(16), .N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .seed_z(seed_z), .seed_w(seed_w), .seed_jsr(seed_jsr), .seed_jcong(seed_jcong),
    .kiss_base(kiss_base), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Software model of the combinational src/dst function.
  task automatic build_expected(input logic [31:0] sz, sw, sj, sc,
                                input logic [15:0] kb, sb, db);
    logic [31:0] z, w, jsr, jc, r;
    int unsigned src [32];
    int unsigned dst [32];
    int unsigned j, t;
    int n;
    z = sz; w = sw; jsr = sj; jc = sc;
    for (int k = 0; k < 32; k++) begin src[k] = k; dst[k] = k; end
    for (int i = 31; i >= 1; i--) begin
      for (int ph = 0; ph < 2; ph++) begin
        z = 32'd36969 * (z & 32'hFFFF) + (z >> 16);
        w = 32'd18000 * (w & 32'hFFFF) + (w >> 16);
        jsr = jsr ^ (jsr << 17);
        jsr = jsr ^ (jsr >> 13);
        jsr = jsr ^ (jsr << 5);
        jc = 32'd69069 * jc + 32'd1234567;
        r = ((((z << 16) + w) ^ jc) + jsr);
        j = r % (i + 1);
        if (ph == 0) begin t = dst[i]; dst[i] = dst[j]; dst[j] = t; end
        else         begin t = src[i]; src[i] = src[j]; src[j] = t; end
      end
    end
    n = 0;
`ifdef SRC_DEST_KISS_STATE_WB_EN
    exp_addr[0] = kb;         exp_data[0] = z;
    exp_addr[1] = kb + 16'd1; exp_data[1] = w;
    exp_addr[2] = kb + 16'd2; exp_data[2] = jsr;
    exp_addr[3] = kb + 16'd3; exp_data[3] = jc;
    n = 4;
`else
    if (kb != 16'hFFFF) n = 0;
`endif
    for (int k = 0; k < 32; k++) begin
      exp_addr[n] = sb + 16'(k); exp_data[n] = src[k]; n++;
      exp_addr[n] = db + 16'(k); exp_data[n] = dst[k]; n++;
    end
  endtask

  // abort: 0 none, 1 reset at cycle 30 (SHUF), 2 reset after 20th handshake
  task automatic do_run(input string name, input logic [31:0] sz, sw, sj, sc,
                        input logic [15:0] kb, sb, db,
                        input bit rnd, input bit glitch, input int abort);
    int c, hs, dones, done_cyc;
    logic [15:0] pa;
    logic [31:0] pd;
    bit pstall;
    build_expected(sz, sw, sj, sc, kb, sb, db);
    @(negedge clk);
    seed_z = sz; seed_w = sw; seed_jsr = sj; seed_jcong = sc;
    kiss_base = kb; src_base = sb; dst_base = db;
    start = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed_z = $urandom; seed_w = $urandom; seed_jsr = $urandom; seed_jcong = $urandom;
    kiss_base = 16'($urandom); src_base = 16'($urandom); dst_base = 16'($urandom);
    c = 1; hs = 0; dones = 0; done_cyc = -1; pstall = 0; pa = '0; pd = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    while (c < 600) begin
      if ((abort == 1 && c == 30) || (abort == 2 && hs == 20)) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, wr_valid} !== 3'b000 || wr_addr !== 16'd0 || wr_data !== 32'd0) begin
          errors++;
          $display("FAIL %s async_reset: got busy=%b done=%b valid=%b addr=%h data=%h expected all 0",
                   name, busy, done, wr_valid, wr_addr, wr_data);
        end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (wr_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s post_reset_quiet: got valid=%b done=%b expected 0 0",
                               name, wr_valid, done);
          end
        end
        rst_n = 1'b1;
        return;
      end
      if (done === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
        end
      end
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = glitch && (c == 10 || c == 70);
      if (pstall) begin
        checks++;
        if (wr_addr !== pa || wr_data !== pd) begin
          errors++; $display("FAIL %s stall_stable: got %h/%h expected %h/%h",
                             name, wr_addr, wr_data, pa, pd);
        end
      end
      if (wr_valid === 1'b1 && wr_ready) begin
        checks++;
        if (hs >= NWORDS) begin
          errors++; $display("FAIL %s extra_write: got write %0d expected at most %0d", name, hs + 1, NWORDS);
        end else begin
          got_data[hs] = wr_data;
          if (wr_addr !== exp_addr[hs] || wr_data !== exp_data[hs]) begin
            errors++; $display("FAIL %s word%0d: got %h/%h expected %h/%h",
                               name, hs, wr_addr, wr_data, exp_addr[hs], exp_data[hs]);
          end
        end
        hs++;
      end
      pstall = (wr_valid === 1'b1) && !wr_ready;
      pa = wr_addr; pd = wr_data;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      errors++; $display("FAIL %s timeout: got no done within %0d cycles expected done", name, c);
    end
    checks++;
    if (hs != NWORDS) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", name, hs, NWORDS);
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, dones);
    end
    if (!rnd) begin
      checks++;
      if (done_cyc != DONE_C) begin
        errors++; $display("FAIL %s done_cycle: got T+%0d expected T+%0d", name, done_cyc, DONE_C);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0;
    seed_z = '0; seed_w = '0; seed_jsr = '0; seed_jcong = '0;
    kiss_base = '0; src_base = '0; dst_base = '0;
    #1;
    checks++;
    if ({busy, done, wr_valid} !== 3'b000 || wr_addr !== 16'd0 || wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b valid=%b addr=%h data=%h expected all 0",
                         busy, done, wr_valid, wr_addr, wr_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, wr_valid} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b done=%b valid=%b expected 000", busy, done, wr_valid);
    end
  endtask

  task automatic test_basic();
    do_run("basic", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'hFFFE, 16'h1000, 16'h2000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stall();
    do_run("stall", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'h0040, 16'hFFF0, 16'h0800, 1'b1, 1'b0, 0);
  endtask

  task automatic test_zero_seed();
    logic [31:0] ms, md;
    do_run("zero_seed", 32'd0, 32'd0, 32'd0, 32'd0,
           16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 0);
    ms = '0; md = '0;
    for (int k = 0; k < 32; k++) begin
      ms[got_data[HDRW + 2 * k][4:0]] = 1'b1;
      md[got_data[HDRW + 2 * k + 1][4:0]] = 1'b1;
    end
    checks++;
    if (ms !== 32'hFFFF_FFFF || md !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL zero_seed_perm: got masks %h %h expected ffffffff ffffffff", ms, md);
    end
  endtask

  task automatic test_random_seeds();
    for (int n = 0; n < 2; n++)
      do_run("random", $urandom, $urandom, $urandom, $urandom,
             16'($urandom), 16'($urandom), 16'($urandom), 1'(n), 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    do_run("start_ignored", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'h0010, 16'h0020, 16'h0060, 1'b0, 1'b1, 0);
    do_run("restart", 32'hDEADBEEF, 32'h12345678, 32'h0BADF00D, 32'hCAFEBABE,
           16'h0500, 16'h0600, 16'h0700, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_abort();
    do_run("abort_shuf", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'h0010, 16'h0020, 16'h0060, 1'b0, 1'b0, 1);
    do_run("after_abort_shuf", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'h0010, 16'h0020, 16'h0060, 1'b0, 1'b0, 0);
    do_run("abort_write", 32'd362436069, 32'd521288629, 32'd123456789, 32'd380116160,
           16'h0010, 16'h0020, 16'h0060, 1'b1, 1'b0, 2);
    do_run("after_abort_write", 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
           16'h0AA0, 16'h0BB0, 16'h0CC0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_seed();
    test_random_seeds();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
